// File: rtl/uart_pkg.sv
// uart_pkg: types, constants and helpers shared by the UART receive and
// transmit paths.
//   rx_state_e         - receiver frame-sequencing states
//   DEFAULT_OVERSAMPLE - oversample ticks per bit period
//   MAX_DATA_BITS      - widest word the parity helper accepts
//   odd_parity()       - parity bit that makes the data plus parity XOR to 1
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP,
    BREAK
  } rx_state_e;

  localparam int DEFAULT_OVERSAMPLE = 16;
  localparam int MAX_DATA_BITS      = 16;

  // Callers zero-extend narrower words. Zero bits do not change an XOR
  // reduction, so one width serves every frame size.
  function automatic logic odd_parity(input logic [MAX_DATA_BITS-1:0] data);
    return ~^data;
  endfunction

endpackage

// File: rtl/uart_sync.sv
// uart_sync: two-flop synchronizer for a single asynchronous input.
//   clk   - destination clock
//   reset - asynchronous active-low reset; both flops load RESET_VAL
//   i_d   - asynchronous input
//   o_q   - synchronized output, two clk of latency
// For idle-high serial lines, RESET_VAL=1 so that reset release does not
// look like a falling edge.
module uart_sync #(
  parameter logic RESET_VAL = 1'b1
) (
  input  logic clk,
  input  logic reset,
  input  logic i_d,
  output logic o_q
);

  logic r_meta;
  logic r_sync;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_meta <= RESET_VAL;
      r_sync <= RESET_VAL;
    end else begin
      r_meta <= i_d;
      r_sync <= r_meta;
    end
  end

  assign o_q = r_sync;

endmodule

// File: rtl/uart_rx.sv
// uart_rx: oversampling UART receiver.
// Frame format: 1 start bit, then DATA_BITS data bits LSB first, then an
// optional odd-parity bit, then 1 stop bit.
//   clk           - system clock
//   reset         - asynchronous active-low reset
//   os_tick       - one-clk pulse at OVERSAMPLE x baud
//   parity_enable - frame carries odd parity (latched at start detect)
//   rx_pin        - asynchronous serial line, idle high
//   rx_data       - last received word, held until next rx_valid
//   rx_valid      - one-clk strobe when rx_data and the error flags update
//   parity_error  - parity mismatch on last frame
//   framing_error - stop bit sampled low on last frame
//   rx_busy       - high while a frame (or a held-low break) is in progress
module uart_rx
  import uart_pkg::*;
#(
  parameter int DATA_BITS  = 8,
  parameter int OVERSAMPLE = DEFAULT_OVERSAMPLE
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 os_tick,
  input  logic                 parity_enable,
  input  logic                 rx_pin,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  output logic                 parity_error,
  output logic                 framing_error,
  output logic                 rx_busy
);

  localparam int CNT_W = $clog2(OVERSAMPLE);
  localparam int IDX_W = $clog2(DATA_BITS + 1);
  localparam logic [CNT_W-1:0] CNT_MID  = CNT_W'(OVERSAMPLE / 2 - 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(OVERSAMPLE - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DATA_BITS - 1);

  logic w_rx_s;

  uart_sync #(.RESET_VAL(1'b1)) u_sync (
    .clk   (clk),
    .reset (reset),
    .i_d   (rx_pin),
    .o_q   (w_rx_s)
  );

  rx_state_e            r_state,         w_state_next;
  logic [CNT_W-1:0]     r_cnt,           w_cnt_next;
  logic [IDX_W-1:0]     r_bit_idx,       w_bit_idx_next;
  logic [DATA_BITS-1:0] r_shift,         w_shift_next;
  logic                 r_par_en,        w_par_en_next;
  logic                 r_perr,          w_perr_next;
  logic [DATA_BITS-1:0] r_rx_data,       w_rx_data_next;
  logic                 r_rx_valid,      w_rx_valid_next;
  logic                 r_parity_error,  w_parity_error_next;
  logic                 r_framing_error, w_framing_error_next;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state         <= IDLE;
      r_cnt           <= '0;
      r_bit_idx       <= '0;
      r_shift         <= '0;
      r_par_en        <= 1'b0;
      r_perr          <= 1'b0;
      r_rx_data       <= '0;
      r_rx_valid      <= 1'b0;
      r_parity_error  <= 1'b0;
      r_framing_error <= 1'b0;
    end else begin
      r_state         <= w_state_next;
      r_cnt           <= w_cnt_next;
      r_bit_idx       <= w_bit_idx_next;
      r_shift         <= w_shift_next;
      r_par_en        <= w_par_en_next;
      r_perr          <= w_perr_next;
      r_rx_data       <= w_rx_data_next;
      r_rx_valid      <= w_rx_valid_next;
      r_parity_error  <= w_parity_error_next;
      r_framing_error <= w_framing_error_next;
    end
  end

  always_comb begin
    w_state_next         = r_state;
    w_cnt_next           = r_cnt;
    w_bit_idx_next       = r_bit_idx;
    w_shift_next         = r_shift;
    w_par_en_next        = r_par_en;
    w_perr_next          = r_perr;
    w_rx_data_next       = r_rx_data;
    w_rx_valid_next      = 1'b0;
    w_parity_error_next  = r_parity_error;
    w_framing_error_next = r_framing_error;

    if (os_tick) begin
      // The counter free-runs and wraps on every tick in all active states.
      // After the mid-start realignment, each wrap lands in the middle of a bit.
      w_cnt_next = r_cnt + 1'b1;
      case (r_state)
        IDLE: begin
          w_cnt_next = '0;
          if (!w_rx_s) begin
            w_state_next  = START;
            w_par_en_next = parity_enable;
          end
        end
        START: begin
          if (r_cnt == CNT_MID) begin
            if (w_rx_s) begin
              w_state_next = IDLE;  // too short to be a start bit
            end else begin
              w_cnt_next     = '0;
              w_bit_idx_next = '0;
              w_state_next   = DATA;
            end
          end
        end
        DATA: begin
          if (r_cnt == CNT_LAST) begin
            // Right shift: after DATA_BITS samples the first bit sits at [0].
            w_shift_next   = {w_rx_s, r_shift[DATA_BITS-1:1]};
            w_bit_idx_next = r_bit_idx + 1'b1;
            if (r_bit_idx == IDX_LAST) begin
              w_state_next = r_par_en ? PARITY : STOP;
            end
          end
        end
        PARITY: begin
          if (r_cnt == CNT_LAST) begin
            w_perr_next  = (w_rx_s != odd_parity(MAX_DATA_BITS'(r_shift)));
            w_state_next = STOP;
          end
        end
        STOP: begin
          if (r_cnt == CNT_LAST) begin
            w_rx_data_next       = r_shift;
            w_parity_error_next  = r_par_en & r_perr;
            w_framing_error_next = ~w_rx_s;
            w_rx_valid_next      = 1'b1;
            // A low stop bit means the line may be held in break. In that
            // case, wait for it to go high before looking for a new start.
            w_state_next = w_rx_s ? IDLE : BREAK;
          end
        end
        BREAK: begin
          if (w_rx_s) begin
            w_state_next = IDLE;
          end
        end
        default: begin
          w_state_next = IDLE;
        end
      endcase
    end
  end

  assign rx_data       = r_rx_data;
  assign rx_valid      = r_rx_valid;
  assign parity_error  = r_parity_error;
  assign framing_error = r_framing_error;
  assign rx_busy       = (r_state != IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: directed self-checking bench for uart_rx (DATA_BITS=8, 16x
// oversample, one os_tick every 4 clk). Each frame that the bench sends
// queues the result it must produce. The result is computed from the frame
// itself: data as sent, a parity error when the ones count over data plus
// parity bit is even, and a framing error when the stop bit is low.
// A compare process checks every cycle: a strobe must match the head of the
// queue, and outside strobes the held outputs must not change.
module tb_uart_rx;

  localparam int DB       = 8;
  localparam int OS       = 16;
  localparam int TICK_DIV = 4;
  localparam int BIT_CLKS = OS * TICK_DIV;

  logic          clk = 1'b0;
  logic          reset;
  logic          os_tick;
  logic          parity_enable;
  logic          rx_pin;
  logic [DB-1:0] rx_data;
  logic          rx_valid;
  logic          parity_error;
  logic          framing_error;
  logic          rx_busy;

  uart_rx #(.DATA_BITS(DB), .OVERSAMPLE(OS)) dut (
    .clk           (clk),
    .reset         (reset),
    .os_tick       (os_tick),
    .parity_enable (parity_enable),
    .rx_pin        (rx_pin),
    .rx_data       (rx_data),
    .rx_valid      (rx_valid),
    .parity_error  (parity_error),
    .framing_error (framing_error),
    .rx_busy       (rx_busy)
  );

  always #5 clk = ~clk;

  initial begin
    os_tick = 1'b0;
    forever begin
      repeat (TICK_DIV - 1) @(negedge clk);
      os_tick = 1'b1;
      @(negedge clk);
      os_tick = 1'b0;
    end
  end

  typedef struct packed {
    logic [DB-1:0] d;
    logic          pe;
    logic          fe;
  } exp_t;

  exp_t          exp_q[$];
  exp_t          cmp_e;
  logic [DB-1:0] m_data = '0;
  logic          m_pe   = 1'b0;
  logic          m_fe   = 1'b0;
  int            n_checks  = 0;
  int            n_pass    = 0;
  int            n_strobes = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  // Per-cycle comparison of the DUT against the model.
  always @(negedge clk) begin
    if (rx_valid) begin
      n_strobes++;
      if (exp_q.size() == 0) begin
        n_checks++;
        $display("FAIL spurious_strobe: rx_valid=1 data=0x%02h with no frame outstanding at %0t",
                 rx_data, $time);
      end else begin
        cmp_e = exp_q.pop_front();
        check("frame_data", rx_data, cmp_e.d);
        check("frame_perr", parity_error, cmp_e.pe);
        check("frame_ferr", framing_error, cmp_e.fe);
        m_data = cmp_e.d;
        m_pe   = cmp_e.pe;
        m_fe   = cmp_e.fe;
        $display("rx frame: data=0x%02h perr=%0d ferr=%0d (expected 0x%02h %0d %0d)",
                 rx_data, parity_error, framing_error, cmp_e.d, cmp_e.pe, cmp_e.fe);
      end
    end else begin
      check("hold_data", rx_data, m_data);
      check("hold_perr", parity_error, m_pe);
      check("hold_ferr", framing_error, m_fe);
    end
  end

  function automatic logic good_par(input logic [DB-1:0] d);
    return ($countones(d) % 2) == 0;
  endfunction

  task automatic send_bit(input logic b);
    rx_pin = b;
    repeat (BIT_CLKS) @(negedge clk);
  endtask

  task automatic idle_bits(input int n);
    repeat (n) send_bit(1'b1);
  endtask

  task automatic send_frame(input logic [DB-1:0] d, input logic par, input logic pbit,
                            input logic stop);
    exp_t e;
    e.d  = d;
    e.pe = par && ((($countones(d) + int'(pbit)) % 2) != 1);
    e.fe = !stop;
    exp_q.push_back(e);
    send_bit(1'b0);
    for (int i = 0; i < DB; i++) send_bit(d[i]);
    if (par) send_bit(pbit);
    send_bit(stop);
  endtask

  task automatic wait_drain(input string name);
    int k;
    k = 0;
    while (exp_q.size() != 0 && k < 4 * BIT_CLKS) begin
      @(negedge clk);
      k++;
    end
    check(name, exp_q.size(), 0);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL global_timeout: simulation did not finish at %0t", $time);
    $fatal(1, "timeout");
  end

  int s0;
  int wk;
  logic busy_seen;
  logic [DB-1:0] loop_vals [4];

  initial begin
    reset         = 1'b0;
    rx_pin        = 1'b1;
    parity_enable = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_data", rx_data, 0);
    check("rst_valid", rx_valid, 0);
    check("rst_perr", parity_error, 0);
    check("rst_ferr", framing_error, 0);
    check("rst_busy", rx_busy, 0);
    reset = 1'b1;
    idle_bits(1);

    // 1: 0x55, no parity
    s0 = n_strobes;
    fork
      send_frame(8'h55, 1'b0, 1'b0, 1'b1);
      begin
        wk = 0;
        while (!rx_valid && wk < 20 * BIT_CLKS) begin
          @(negedge clk);
          wk++;
        end
        check("t1_strobe_seen", rx_valid, 1);
        repeat (TICK_DIV) @(negedge clk);
        check("t1_busy_cleared", rx_busy, 0);
      end
    join
    idle_bits(1);
    wait_drain("t1_drain");
    check("t1_strobes", n_strobes - s0, 1);
    check("t1_data_lit", rx_data, 8'h55);
    check("t1_perr_lit", parity_error, 0);
    check("t1_ferr_lit", framing_error, 0);

    // 2: odd parity good then bad
    parity_enable = 1'b1;
    s0 = n_strobes;
    send_frame(8'hA5, 1'b1, 1'b1, 1'b1);
    idle_bits(1);
    check("t2a_data_lit", rx_data, 8'hA5);
    check("t2a_perr_lit", parity_error, 0);
    send_frame(8'hA5, 1'b1, 1'b0, 1'b1);
    idle_bits(1);
    check("t2b_perr_lit", parity_error, 1);
    check("t2b_data_lit", rx_data, 8'hA5);
    check("t2_strobes", n_strobes - s0, 2);
    parity_enable = 1'b0;

    // 3: glitch of 4 ticks
    s0 = n_strobes;
    busy_seen = 1'b0;
    rx_pin = 1'b0;
    repeat (4 * TICK_DIV) begin
      @(negedge clk);
      if (rx_busy) busy_seen = 1'b1;
    end
    rx_pin = 1'b1;
    repeat (2 * BIT_CLKS) begin
      @(negedge clk);
      if (rx_busy) busy_seen = 1'b1;
    end
    check("t3_busy_seen", busy_seen, 1);
    check("t3_busy_clear", rx_busy, 0);
    check("t3_strobes", n_strobes - s0, 0);

    // 4: framing error, held break, then a clean frame
    s0 = n_strobes;
    send_frame(8'h3C, 1'b0, 1'b0, 1'b0);
    repeat (20) send_bit(1'b0);
    check("t4_busy_in_break", rx_busy, 1);
    check("t4_strobes_break", n_strobes - s0, 1);
    check("t4_data_lit", rx_data, 8'h3C);
    check("t4_ferr_lit", framing_error, 1);
    idle_bits(2);
    check("t4_busy_after_break", rx_busy, 0);
    send_frame(8'h81, 1'b0, 1'b0, 1'b1);
    idle_bits(1);
    check("t4_data2_lit", rx_data, 8'h81);
    check("t4_ferr2_lit", framing_error, 0);
    check("t4_strobes", n_strobes - s0, 2);

    // 5: reset during data bit 4 of 0xF0
    s0 = n_strobes;
    send_bit(1'b0);
    for (int i = 0; i < 4; i++) send_bit(1'b0);
    rx_pin = 1'b1;
    repeat (BIT_CLKS / 2) @(negedge clk);
    check("t5_busy_pre_reset", rx_busy, 1);
    #1;
    reset  = 1'b0;
    m_data = '0;
    m_pe   = 1'b0;
    m_fe   = 1'b0;
    exp_q.delete();
    #1;
    check("t5_rst_data", rx_data, 0);
    check("t5_rst_valid", rx_valid, 0);
    check("t5_rst_perr", parity_error, 0);
    check("t5_rst_ferr", framing_error, 0);
    check("t5_rst_busy", rx_busy, 0);
    rx_pin = 1'b1;
    repeat (5) @(negedge clk);
    reset = 1'b1;
    idle_bits(1);
    check("t5_no_stray", n_strobes - s0, 0);
    send_frame(8'h0F, 1'b0, 1'b0, 1'b1);
    idle_bits(1);
    check("t5_data_lit", rx_data, 8'h0F);
    check("t5_strobes", n_strobes - s0, 1);

    // 6: back-to-back parity frames as a transmitter would produce them
    parity_enable = 1'b1;
    loop_vals[0] = 8'h00;
    loop_vals[1] = 8'hFF;
    loop_vals[2] = 8'h5A;
    loop_vals[3] = 8'hC3;
    s0 = n_strobes;
    for (int i = 0; i < 4; i++) send_frame(loop_vals[i], 1'b1, good_par(loop_vals[i]), 1'b1);
    idle_bits(1);
    wait_drain("t6_drain");
    check("t6_strobes", n_strobes - s0, 4);
    check("t6_data_lit", rx_data, 8'hC3);
    check("t6_perr_lit", parity_error, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
